game_state_controller: RTL and testbench



---
 rtl/game_state_controller.sv | 166 ++++++++++++++++
 tb/tb_game_state_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_controller.sv
// Frogger game-flow controller: IDLE / RUNNING / DYING / LEVEL_UP / GAME_OVER with lives, level and lane mask.
// Define GAME_EXTRA_LIFE_EN to award a life on every level that is a nonzero multiple of 4.
module game_state_controller #(
    parameter int NUM_LANES    = 4,
    parameter int LEVEL_WIDTH  = 4,
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = 7,
    parameter int DEATH_CYCLES = 25_000_000,
    parameter int LEVEL_CYCLES = 12_500_000,
    localparam int L = $clog2(MAX_LIVES + 1)
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Start,
    input  logic                   i_Has_Collided,
    input  logic                   i_Level_Up,
    input  logic [NUM_LANES-1:0]   i_LFSR_Data,
    output logic                   o_Game_Active,
    output logic                   o_Frog_Reset,
    output logic [L-1:0]           o_Lives,
    output logic [LEVEL_WIDTH-1:0] o_Level,
    output logic [NUM_LANES-1:0]   o_Reverse,
    output logic [2:0]             o_State,
    output logic                   o_Game_Over
);

    localparam int MAX_CYC = (DEATH_CYCLES > LEVEL_CYCLES) ? DEATH_CYCLES : LEVEL_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0]          DEATH_LAST = TW'(DEATH_CYCLES - 1);
    localparam logic [TW-1:0]          LEVEL_LAST = TW'(LEVEL_CYCLES - 1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX  = '1;
`ifdef GAME_EXTRA_LIFE_EN
    localparam logic [L-1:0]           LIVES_MAX  = L'(MAX_LIVES);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUNNING   = 3'd1,
        S_DYING     = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [L-1:0]           lives_q, lives_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [NUM_LANES-1:0]   reverse_q, reverse_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   frog_q, frog_d;
    logic                   active_q, over_q;
    logic                   start_prev_q;
    logic                   release_q;

    logic                   start_edge;
    logic [NUM_LANES-1:0]   lane_mask;
    logic [LEVEL_WIDTH:0]   level_plus;

    assign start_edge = i_Start & ~start_prev_q;
    // An all-zero mask would leave every lane unchanged; force the LSB instead.
    assign lane_mask  = (i_LFSR_Data == '0) ? NUM_LANES'(1) : i_LFSR_Data;
    assign level_plus = {1'b0, level_q} + (LEVEL_WIDTH + 1)'(1);

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        reverse_d = release_q ? lane_mask : reverse_q;
        timer_d   = timer_q;
        frog_d    = 1'b0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    lives_d   = L'(START_LIVES);
                    level_d   = '0;
                    reverse_d = lane_mask;
                    timer_d   = '0;
                    frog_d    = 1'b1;
                    state_d   = S_RUNNING;
                end
            end
            S_RUNNING: begin
                // Collision outranks a same-cycle level-up.
                if (i_Has_Collided) begin
                    timer_d = '0;
                    if (lives_q > L'(1)) begin
                        lives_d = lives_q - L'(1);
                        state_d = S_DYING;
                    end else begin
                        lives_d = '0;
                        state_d = S_GAME_OVER;
                    end
                end else if (i_Level_Up) begin
                    if (level_q != LEVEL_MAX) begin
                        level_d = level_plus[LEVEL_WIDTH-1:0];
`ifdef GAME_EXTRA_LIFE_EN
                        if (level_plus[1:0] == 2'b00 && lives_q != LIVES_MAX) begin
                            lives_d = lives_q + L'(1);
                        end
`endif
                    end
                    reverse_d = lane_mask;
                    timer_d   = '0;
                    state_d   = S_LEVEL_UP;
                end
            end
            S_DYING: begin
                if (timer_q == DEATH_LAST) begin
                    timer_d = '0;
                    frog_d  = 1'b1;
                    state_d = S_RUNNING;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_LEVEL_UP: begin
                if (timer_q == LEVEL_LAST) begin
                    timer_d = '0;
                    frog_d  = 1'b1;
                    state_d = S_RUNNING;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q      <= S_IDLE;
            lives_q      <= '0;
            level_q      <= '0;
            reverse_q    <= NUM_LANES'(1);
            timer_q      <= '0;
            frog_q       <= 1'b0;
            active_q     <= 1'b0;
            over_q       <= 1'b0;
            start_prev_q <= 1'b1;
            release_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            reverse_q    <= reverse_d;
            timer_q      <= timer_d;
            frog_q       <= frog_d;
            active_q     <= (state_d == S_RUNNING);
            over_q       <= (state_d == S_GAME_OVER);
            start_prev_q <= i_Start;
            release_q    <= 1'b0;
        end
    end

    assign o_Game_Active = active_q;
    assign o_Frog_Reset  = frog_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_Reverse     = reverse_q;
    assign o_State       = state_q;
    assign o_Game_Over   = over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a countdown-based reference model.
module tb_game_state_controller;

    localparam int NL = 4;
    localparam int LW = 4;
    localparam int SL = 3;
    localparam int ML = 7;
    localparam int DC = 4;
    localparam int LC = 3;

    logic       clk = 1'b0;
    logic       rst_l, start, coll, lvl;
    logic [3:0] lfsr;
    logic       active, frog, over;
    logic [2:0] lives;
    logic [3:0] level, rev;
    logic [2:0] st;

    always #5 clk = ~clk;

    game_state_controller #(
        .NUM_LANES(NL), .LEVEL_WIDTH(LW), .START_LIVES(SL), .MAX_LIVES(ML),
        .DEATH_CYCLES(DC), .LEVEL_CYCLES(LC)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Start(start), .i_Has_Collided(coll),
        .i_Level_Up(lvl), .i_LFSR_Data(lfsr), .o_Game_Active(active),
        .o_Frog_Reset(frog), .o_Lives(lives), .o_Level(level), .o_Reverse(rev),
        .o_State(st), .o_Game_Over(over)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] lives;
        logic [3:0] level;
        logic [3:0] rev;
        logic       act;
        logic       frog;
        logic       over;
    } obs_t;

    typedef struct {
        logic       r, s, c, u;
        logic [3:0] d;
        obs_t       exp;
    } vec_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a countdown of remaining pause clocks, integers for everything.
    int         m_st, m_lives, m_level, m_remain;
    logic [3:0] m_rev;
    logic       m_frog, m_prev, m_first;

    function automatic logic [3:0] mask_of(input logic [3:0] d);
        return (d == 4'd0) ? 4'b0001 : d;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic c, input logic u,
                              input logic [3:0] d);
        logic rise;
        obs_t o;
        if (!r) begin
            m_st = 0; m_lives = 0; m_level = 0; m_rev = 4'b0001;
            m_frog = 1'b0; m_prev = 1'b1; m_first = 1'b1; m_remain = 0;
        end else begin
            rise = s && !m_prev;
            m_prev = s;
            m_frog = 1'b0;
            if (m_first) m_rev = mask_of(d);
            m_first = 1'b0;
            case (m_st)
                0, 4: if (rise) begin
                    m_lives = SL; m_level = 0; m_rev = mask_of(d); m_frog = 1'b1; m_st = 1;
                end
                1: begin
                    if (c) begin
                        if (m_lives > 1) begin
                            m_lives = m_lives - 1; m_st = 2; m_remain = DC;
                        end else begin
                            m_lives = 0; m_st = 4;
                        end
                    end else if (u) begin
                        if (m_level < (1 << LW) - 1) begin
                            m_level = m_level + 1;
`ifdef GAME_EXTRA_LIFE_EN
                            if (m_level % 4 == 0 && m_lives < ML) m_lives = m_lives + 1;
`endif
                        end
                        m_rev = mask_of(d); m_st = 3; m_remain = LC;
                    end
                end
                default: begin
                    m_remain = m_remain - 1;
                    if (m_remain == 0) begin
                        m_st = 1; m_frog = 1'b1;
                    end
                end
            endcase
        end
        o.st = 3'(m_st); o.lives = 3'(m_lives); o.level = 4'(m_level); o.rev = m_rev;
        o.act = (m_st == 1); o.frog = m_frog; o.over = (m_st == 4);
        exp_q.push_back(o);
    endtask

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = '{st: st, lives: lives, level: level, rev: rev, act: active, frog: frog, over: over};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got st=%0d lives=%0d level=%0d rev=%b act=%b frog=%b over=%b, want st=%0d lives=%0d level=%0d rev=%b act=%b frog=%b over=%b",
                     name, a.st, a.lives, a.level, a.rev, a.act, a.frog, a.over,
                     e.st, e.lives, e.level, e.rev, e.act, e.frog, e.over);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic c, input logic u,
                         input logic [3:0] d, input string name);
        rst_l = r; start = s; coll = c; lvl = u; lfsr = d;
        @(posedge clk);
        model_step(r, s, c, u, d);
        #1;
        check(name, exp_q.pop_front());
    endtask

    task automatic wait_running(input string name);
        int n = 0;
        while (st != 3'd1 && n < 20) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), name);
            n++;
        end
        check_int(name, int'(st), 1);
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic c, input logic u,
                                input logic [3:0] d, input logic [2:0] est, input logic [2:0] eli,
                                input logic [3:0] elv, input logic [3:0] erv,
                                input logic ea, input logic ef, input logic eo);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.u = u; v.d = d;
        v.exp = '{st: est, lives: eli, level: elv, rev: erv, act: ea, frog: ef, over: eo};
        return v;
    endfunction

    vec_t tbl[26];
    int   pulses;
    int   want_lives;

    initial begin
        rst_l = 1'b0; start = 1'b0; coll = 1'b0; lvl = 1'b0; lfsr = 4'd0;

        //            r  s  c  u  lfsr   st li lv rev      a  f  o
        tbl[0]  = mk(0, 0, 0, 0, 4'd0,  0, 0, 0, 4'b0001, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 4'd0,  0, 0, 0, 4'b0001, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 4'd6,  0, 0, 0, 4'b0110, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 4'd3,  1, 3, 0, 4'b0011, 1, 1, 0);
        tbl[4]  = mk(1, 1, 0, 0, 4'd5,  1, 3, 0, 4'b0011, 1, 0, 0);
        tbl[5]  = mk(1, 0, 1, 0, 4'd5,  2, 2, 0, 4'b0011, 0, 0, 0);
        tbl[6]  = mk(1, 0, 1, 1, 4'd5,  2, 2, 0, 4'b0011, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 4'd5,  2, 2, 0, 4'b0011, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 4'd5,  2, 2, 0, 4'b0011, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 4'd5,  1, 2, 0, 4'b0011, 1, 1, 0);
        tbl[10] = mk(1, 0, 0, 1, 4'd0,  3, 2, 1, 4'b0001, 0, 0, 0);
        tbl[11] = mk(1, 0, 1, 0, 4'd9,  3, 2, 1, 4'b0001, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 4'd9,  3, 2, 1, 4'b0001, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 4'd9,  1, 2, 1, 4'b0001, 1, 1, 0);
        tbl[14] = mk(1, 0, 0, 1, 4'd10, 3, 2, 2, 4'b1010, 0, 0, 0);
        tbl[15] = mk(1, 0, 0, 0, 4'd7,  3, 2, 2, 4'b1010, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, 0, 4'd7,  3, 2, 2, 4'b1010, 0, 0, 0);
        tbl[17] = mk(1, 0, 0, 0, 4'd7,  1, 2, 2, 4'b1010, 1, 1, 0);
        tbl[18] = mk(1, 0, 1, 1, 4'd7,  2, 1, 2, 4'b1010, 0, 0, 0);
        tbl[19] = mk(1, 0, 0, 0, 4'd7,  2, 1, 2, 4'b1010, 0, 0, 0);
        tbl[20] = mk(1, 0, 0, 0, 4'd7,  2, 1, 2, 4'b1010, 0, 0, 0);
        tbl[21] = mk(1, 0, 0, 0, 4'd7,  2, 1, 2, 4'b1010, 0, 0, 0);
        tbl[22] = mk(1, 0, 0, 0, 4'd7,  1, 1, 2, 4'b1010, 1, 1, 0);
        tbl[23] = mk(1, 0, 1, 0, 4'd7,  4, 0, 2, 4'b1010, 0, 0, 1);
        tbl[24] = mk(1, 0, 0, 0, 4'd7,  4, 0, 2, 4'b1010, 0, 0, 1);
        tbl[25] = mk(1, 1, 0, 0, 4'd12, 1, 3, 0, 4'b1100, 1, 1, 0);

        #2;
        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].u, tbl[i].d, $sformatf("model[%0d]", i));
            check($sformatf("table[%0d]", i), tbl[i].exp);
        end

        // Holding the start switch must not produce further respawn pulses.
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)), "hold_start");
            pulses += int'(frog);
        end
        check_int("hold_start_pulses", pulses, 0);

        // Three collisions run lives out; a fresh start edge restarts.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, "release_start");
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, "collide");
            if (k < 2) wait_running("death_return");
        end
        check_int("gameover_lives", int'(lives), 0);
        check_int("gameover_state", int'(st), 4);
        check_int("gameover_flag", int'(over), 1);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, "restart");
        check_int("restart_lives", int'(lives), 3);
        check_int("restart_level", int'(level), 0);
        check_int("restart_state", int'(st), 1);

        // Reset on the second DYING clock aborts the pause with no respawn.
        apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, "dying_1");
        apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, "dying_2");
        apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, "mid_dying_reset");
        check_int("mid_reset_state", int'(st), 0);
        check_int("mid_reset_lives", int'(lives), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, "post_reset");
            pulses += int'(frog);
        end
        check_int("post_reset_pulses", pulses, 0);

        // Four level-ups: lives gain one only when the bonus build is selected.
        apply(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, "start_for_levels");
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)), "level_up");
            wait_running("level_return");
        end
`ifdef GAME_EXTRA_LIFE_EN
        want_lives = 4;
`else
        want_lives = 3;
`endif
        check_int("four_levels_level", int'(level), 4);
        check_int("four_levels_lives", int'(lives), want_lives);

        // Randomized traffic against the reference model.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "random_prep");
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 199) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
